// File: rtl/debug_bp_if.sv
// Debug/breakpoint bus: config writes, commit stream, halt/step control
// and the status outputs of debug_bp_unit.
interface debug_bp_if #(
    parameter int NUM_BP = 8,
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 3,
    parameter int PART_W = 3,
    parameter int CNT_W  = 16
);
    logic              cfg_set;
    logic              cfg_clear;
    logic [IDX_W-1:0]  cfg_index;
    logic [PART_W-1:0] cfg_part;
    logic [7:0]        cfg_value;
    logic              halt_req;
    logic              step_req;
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_pc;
    logic              debug_flag;
    logic              debug_step;
    logic [NUM_BP-1:0] bp_valid;
    logic [NUM_BP-1:0] bp_get;
    logic              bp_happen;
    logic [IDX_W-1:0]  bp_hit_idx;
    logic [CNT_W-1:0]  halt_cnt;
    logic [1:0]        state;

    modport master (
        output cfg_set, cfg_clear, cfg_index, cfg_part, cfg_value,
        output halt_req, step_req, commit_valid, commit_pc,
        input  debug_flag, debug_step, bp_valid, bp_get,
        input  bp_happen, bp_hit_idx, halt_cnt, state
    );

    modport slave (
        input  cfg_set, cfg_clear, cfg_index, cfg_part, cfg_value,
        input  halt_req, step_req, commit_valid, commit_pc,
        output debug_flag, debug_step, bp_valid, bp_get,
        output bp_happen, bp_hit_idx, halt_cnt, state
    );
endinterface

// File: rtl/debug_bp_unit.sv
// PC breakpoint table plus RUN/HALT/STEP controller that stalls the core,
// issues single-step pulses and resumes past the breakpoint it hit.
module debug_bp_unit #(
    parameter int NUM_BP = 8,
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 3,
    parameter int PART_W = 3,
    parameter int CNT_W  = 16
) (
    input logic       clk,
    input logic       rstn,
    debug_bp_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam int NBYTE = ADDR_W / 8;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_entry [NUM_BP];
    logic [NUM_BP-1:0] r_valid;
    logic [NUM_BP-1:0] w_get;
    logic [IDX_W-1:0]  r_hit_idx, w_low_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_skip, r_hreq_q, r_flag, r_step, r_happen;
    logic              w_hit, w_happen, w_step, w_inc, w_resume;

    // Clear beats set; indices beyond NUM_BP never match any entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_BP; i++) r_entry[i] <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bus.cfg_index == IDX_W'(i)) begin
                    if (bus.cfg_clear) begin
                        r_entry[i] <= '0;
                        r_valid[i] <= 1'b0;
                    end else if (bus.cfg_set) begin
                        r_valid[i] <= 1'b1;
                        for (int b = 0; b < NBYTE; b++) begin
                            if (bus.cfg_part == PART_W'(b))
                                r_entry[i][8*b +: 8] <= bus.cfg_value;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_get = '0;
        for (int i = 0; i < NUM_BP; i++)
            w_get[i] = bus.commit_valid & r_valid[i] &
                       (bus.commit_pc == r_entry[i]);
    end

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--)
            if (w_get[i]) w_low_idx = IDX_W'(i);
    end

    assign w_hit = (|w_get) & ~r_skip;

    always_comb begin
        w_next   = r_state;
        w_happen = 1'b0;
        w_step   = 1'b0;
        w_inc    = 1'b0;
        w_resume = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (w_hit) begin
                    w_next   = S_HALT;
                    w_happen = 1'b1;
                end else if (bus.halt_req) begin
                    w_next = S_HALT;
                end
                w_inc = (w_next == S_HALT);
            end
            S_HALT: begin
                if (bus.step_req) begin
                    w_next = S_STEP;
                    w_step = 1'b1;
                end else if (r_hreq_q & ~bus.halt_req) begin
                    w_next   = S_RUN;
                    w_resume = 1'b1;
                end
            end
            S_STEP: begin
                if (bus.commit_valid) w_next = S_HALT;
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_RUN;
            r_flag    <= 1'b0;
            r_step    <= 1'b0;
            r_happen  <= 1'b0;
            r_hit_idx <= '0;
            r_cnt     <= '0;
            r_skip    <= 1'b0;
            r_hreq_q  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_flag   <= (w_next != S_RUN);
            r_step   <= w_step;
            r_happen <= w_happen;
            r_hreq_q <= bus.halt_req;
            if (w_happen) r_hit_idx <= w_low_idx;
            if (w_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
            // Lets the halted instruction retire once after resume.
            if (w_resume) r_skip <= 1'b1;
            else if (bus.commit_valid) r_skip <= 1'b0;
        end
    end

    assign bus.debug_flag = r_flag;
    assign bus.debug_step = r_step;
    assign bus.bp_valid   = r_valid;
    assign bus.bp_get     = w_get;
    assign bus.bp_happen  = r_happen;
    assign bus.bp_hit_idx = r_hit_idx;
    assign bus.halt_cnt   = r_cnt;
    assign bus.state      = r_state;
endmodule
